alu_bit_serializer: RTL and testbench
=====================================

# alu_bit_serializer

Parallel-to-serial converter for the ALU bit-select path. It captures an 8-bit ALU result and drives the 3-bit select of an 8:1 bit multiplexer through every bit position in turn, either LSB-first or MSB-first. It presents the selected bit on a valid/ready serial stream, and the stream can optionally end with an even-parity beat. The block sits directly upstream of the 8:1 selector: it produces the select and consumes the selected bit.

## Interface
Parameters:
- WIDTH, 8, word width; fixed at 8 for this block, giving a 3-bit select.
- SEL_W, 3, select width; equals log2(WIDTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  upstream presents a word on data_in.
- load_ready  out  1  block can accept a word; high only in IDLE.
- data_in  in  8  word to serialize.
- msb_first  in  1  bit order, sampled with the word; 1 = bit 7 first, 0 = bit 0 first.
- ser_ready  in  1  downstream accepts the current beat.
- ser_valid  out  1  ser_out carries a valid beat.
- ser_out  out  1  current serial bit: the selected bit of the word register, or the parity bit.
- ser_last  out  1  marks the final beat of the word.
- sel  out  3  current select value driven to the bit selector; exported for debug.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with SER_PARITY_EN).
- IDLE
  - load_ready=1, ser_valid=0.
  - On load_valid && load_ready: latch data_in into word_q and msb_first into dir_q.
  - Set sel to 7 if dir_q=1, else 0. Clear the beat counter. Go to SHIFT.
- SHIFT
  - ser_valid=1; ser_out = word_q[sel].
  - A beat transfers on ser_valid && ser_ready.
  - On each transfer, sel steps by -1 (MSB-first) or +1 (LSB-first) and the beat counter increments.
  - Without ser_ready, sel, ser_out and the counter all hold.
- Final data beat is beat 7.
  - Without parity: ser_last=1 on beat 7; its transfer returns the block to IDLE.
  - With parity: ser_last=0 on beat 7; its transfer moves the block to PARITY.
- PARITY
  - ser_valid=1, ser_last=1, ser_out = XOR of word_q bits (even parity).
  - Transfer returns the block to IDLE.
- load_valid, data_in and msb_first are ignored outside IDLE.
- sel arithmetic is modulo 8. The wrap after the final beat is don't-care because the state leaves SHIFT.
- Word and direction registers hold their value in IDLE.

## Timing
- Reset values: state=IDLE, word_q=0, dir_q=0, sel=0, counter=0.
- Outputs during and after reset: load_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
- Reset mid-word aborts immediately. No partial beat is emitted after reset deasserts.
- A load accepted at edge k produces the first beat valid in cycle k+1. ser_out, ser_valid, ser_last and sel are all registered-state decodes, with no combinational path from inputs.
- With ser_ready held high:
  - 8 beats occupy cycles k+1..k+8; load_ready returns in cycle k+9.
  - Throughput is one word per 9 cycles without parity, 10 with parity.
- Back-to-back loads are not supported: there is at least one IDLE cycle between words.
- ser_ready may toggle arbitrarily. Once ser_valid is asserted, it stays high until the transfer occurs.

## Configuration
- SER_PARITY_EN defined: the PARITY state exists and each word is 9 beats, with ser_last on the parity beat.
- SER_PARITY_EN undefined: the PARITY state and parity logic are removed and each word is 8 beats, with ser_last on bit beat 7.

## Structure
- Shared package ser_pkg holds:
  - WIDTH and SEL_W constants.
  - State encoding: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10.
  - Final-beat constant LAST_BEAT=3'd7.
- One sub-module, bit_sel8: a combinational 8:1 selector with inputs word[7:0] and sel[2:0], and output bit. Instantiate it once; its output feeds ser_out in SHIFT.
- The FSM, the sel up/down counter, the beat counter and the parity XOR stay in the top module.

## Test plan
- LSB-first: load 8'h0F, msb_first=0, ser_ready=1.
  - Expect ser_out 1,1,1,1,0,0,0,0 and sel 0..7 in cycles k+1..k+8.
  - Expect ser_last only in cycle k+8 and load_ready=1 in cycle k+9.
- MSB-first: load 8'h0F, msb_first=1.
  - Expect ser_out 0,0,0,0,1,1,1,1 and sel 7..0.
- Backpressure: load 8'hA6 LSB-first, drop ser_ready in cycles k+3..k+5.
  - Expect sel=2 and ser_out=1 to hold through the stall.
  - Expect the full sequence 0,1,1,0,0,1,0,1 with no beat lost or duplicated.
- Busy-ignore: during SHIFT, assert load_valid with data_in=8'hFF.
  - Expect load_ready=0 and the original word's sequence unchanged.
- Reset mid-word: assert rst at beat 4.
  - Expect all outputs at reset values in the same cycle.
  - After deassertion, a new load of 8'h01 LSB-first yields 1,0,0,0,0,0,0,0.
- Parity: with SER_PARITY_EN, load 8'h07 LSB-first.
  - Expect a 9th beat ser_out=1 with ser_last=1, and no ser_last on beat 8.
  - Without the macro, expect 8 beats only.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared constants and state encoding for the ALU bit serializer.
package ser_pkg;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_e;

    localparam logic [SEL_W-1:0] LAST_BEAT = 3'd7;

endpackage

// File: rtl/bit_sel8.sv
// Combinational 8:1 bit selector fed by the serializer's select output.
module bit_sel8 (
    input  logic [7:0] word,
    input  logic [2:0] sel,
    output logic       bit_o
);

    assign bit_o = word[sel];

endmodule

// File: rtl/alu_bit_serializer.sv
// Serializes an 8-bit ALU result through an 8:1 bit selector onto a valid/ready stream.
// Define SER_PARITY_EN to append an even-parity beat after the eight data beats.
module alu_bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = ser_pkg::WIDTH,
    parameter int SEL_W = ser_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_last,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    localparam logic [SEL_W-1:0] SEL_ONE = 1;

    state_e           state_q;
    logic [WIDTH-1:0] word_q;
    logic             dir_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] cnt_q;
    logic             selBit;

    bit_sel8 u_bit_sel8 (
        .word  (word_q),
        .sel   (sel_q),
        .bit_o (selBit)
    );

    // Modulo-8 step; the wrap after the final beat is never observed in SHIFT.
    assign sel_d = dir_q ? (sel_q - SEL_ONE) : (sel_q + SEL_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            dir_q   <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        word_q  <= data_in;
                        dir_q   <= msb_first;
                        sel_q   <= msb_first ? '1 : '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        sel_q <= sel_d;
                        cnt_q <= cnt_q + SEL_ONE;
                        if (cnt_q == LAST_BEAT) begin
`ifdef SER_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= IDLE;
`endif
                        end
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    if (ser_ready) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // All stream outputs decode registered state only, so no input reaches them combinationally.
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ser_valid  = (state_q != IDLE);
    assign sel        = sel_q;

`ifdef SER_PARITY_EN
    assign ser_out  = ((state_q == SHIFT) && selBit) || ((state_q == PARITY) && (^word_q));
    assign ser_last = (state_q == PARITY);
`else
    assign ser_out  = (state_q == SHIFT) && selBit;
    assign ser_last = (state_q == SHIFT) && (cnt_q == LAST_BEAT);
`endif

endmodule

// File: tb/tb_alu_bit_serializer.sv
// Scoreboard bench for alu_bit_serializer; honours SER_PARITY_EN when defined.
module tb_alu_bit_serializer;

    typedef struct packed {
        logic       b;
        logic [2:0] s;
        logic       last;
        logic       chkSel;
    } beat_t;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] data_in;
    logic       msb_first;
    logic       ser_ready;
    logic       ser_valid;
    logic       ser_out;
    logic       ser_last;
    logic [2:0] sel;
    logic       busy;

    int    checks = 0;
    int    errors = 0;
    beat_t expQ[$];

    alu_bit_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .msb_first  (msb_first),
        .ser_ready  (ser_ready),
        .ser_valid  (ser_valid),
        .ser_out    (ser_out),
        .ser_last   (ser_last),
        .sel        (sel),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat sequence built independently from the word and bit order.
    task automatic pushWord(input logic [7:0] d, input logic dir);
        beat_t e;
        logic [2:0] idx;
        for (int i = 0; i < 8; i++) begin
            idx      = dir ? 3'(7 - i) : 3'(i);
            e.b      = d[idx];
            e.s      = idx;
            e.chkSel = 1'b1;
`ifdef SER_PARITY_EN
            e.last   = 1'b0;
`else
            e.last   = (i == 7);
`endif
            expQ.push_back(e);
        end
`ifdef SER_PARITY_EN
        e.b      = ^d;
        e.s      = 3'd0;
        e.last   = 1'b1;
        e.chkSel = 1'b0;
        expQ.push_back(e);
`endif
    endtask

    // Drive one word from an IDLE cycle; returns in cycle k+1.
    task automatic applyStimulus(input logic [7:0] d, input logic dir);
        checkOutput("loadRdy", {7'd0, load_ready}, 8'd1);
        load_valid = 1'b1;
        data_in    = d;
        msb_first  = dir;
        pushWord(d, dir);
        tick();
        load_valid = 1'b0;
        data_in    = 8'h00;
        msb_first  = 1'b0;
    endtask

    task automatic waitIdle(input logic randReady);
        bit done = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (load_ready && expQ.size() == 0) done = 1;
            else begin
                if (randReady) ser_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        ser_ready = 1'b1;
        if (!done) checkOutput("timeout", 8'd0, 8'd1);
        checkOutput("qEmpty", 8'(expQ.size()), 8'd0);
    endtask

    task automatic checkReset();
        checkOutput("rstLoadRdy", {7'd0, load_ready}, 8'd1);
        checkOutput("rstValid",   {7'd0, ser_valid},  8'd0);
        checkOutput("rstOut",     {7'd0, ser_out},    8'd0);
        checkOutput("rstLast",    {7'd0, ser_last},   8'd0);
        checkOutput("rstBusy",    {7'd0, busy},       8'd0);
        checkOutput("rstSel",     {5'd0, sel},        8'd0);
    endtask

    // Every accepted beat is popped and compared against the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && ser_valid && ser_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpBeat", 8'd1, 8'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("beatOut",  {7'd0, ser_out},  {7'd0, e.b});
                checkOutput("beatLast", {7'd0, ser_last}, {7'd0, e.last});
                if (e.chkSel) checkOutput("beatSel", {5'd0, sel}, {5'd0, e.s});
            end
        end
    end

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        data_in    = 8'h00;
        msb_first  = 1'b0;
        ser_ready  = 1'b1;
        #1;
        checkReset();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // LSB-first with exact latency checks.
        applyStimulus(8'h0F, 1'b0);
        checkOutput("k1Busy",  {7'd0, busy},       8'd1);
        checkOutput("k1Rdy",   {7'd0, load_ready}, 8'd0);
        checkOutput("k1Valid", {7'd0, ser_valid},  8'd1);
        for (int i = 0; i < NB; i++) tick();
        checkOutput("k9Rdy",   {7'd0, load_ready}, 8'd1);
        checkOutput("k9Valid", {7'd0, ser_valid},  8'd0);
        waitIdle(1'b0);
        tick();

        // MSB-first.
        applyStimulus(8'h0F, 1'b1);
        checkOutput("msbSel0", {5'd0, sel}, 8'd7);
        waitIdle(1'b0);
        tick();

        // Backpressure in cycles k+3..k+5.
        applyStimulus(8'hA6, 1'b0);
        tick();
        tick();
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stallSel", {5'd0, sel}, 8'd2);
            checkOutput("stallOut", {7'd0, ser_out}, 8'd1);
            checkOutput("stallVld", {7'd0, ser_valid}, 8'd1);
            if (i < 2) tick();
        end
        ser_ready = 1'b1;
        waitIdle(1'b0);
        tick();

        // Loads presented while busy must be ignored.
        applyStimulus(8'h3C, 1'b1);
        load_valid = 1'b1;
        data_in    = 8'hFF;
        msb_first  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("busyRdy", {7'd0, load_ready}, 8'd0);
            tick();
        end
        load_valid = 1'b0;
        data_in    = 8'h00;
        waitIdle(1'b0);
        tick();

        // Reset at beat 4 aborts immediately.
        applyStimulus(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("preRstSel", {5'd0, sel}, 8'd4);
        rst = 1'b1;
        expQ.delete();
        #1;
        checkReset();
        tick();
        rst = 1'b0;
        checkReset();
        tick();
        applyStimulus(8'h01, 1'b0);
        waitIdle(1'b0);
        tick();

        // Parity word (8 beats when parity is disabled).
        applyStimulus(8'h07, 1'b0);
        waitIdle(1'b0);
        tick();

        // Random words under random backpressure.
        for (int w = 0; w < 12; w++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            waitIdle(1'b1);
            if (w % 3 == 0) tick();
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
